fast_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 20 ++
 rtl/restoring_div_step.sv | 31 +++
 rtl/fast_divider.sv | 158 +++++++++++++++
 tb/tb_fast_divider.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative divider.
//   div_state_e : control FSM states (IDLE accepts operands, CALC runs the loop)
//   CNT_W       : iteration counter width for the default 8-bit divider
//   cnt_width() : counter width for an arbitrary divisor width
package divider_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_e;

    localparam int unsigned DIN_W_DEFAULT = 8;
    localparam int unsigned CNT_W         = $clog2(DIN_W_DEFAULT);

    // At least one bit so the counter never collapses to zero width.
    function automatic int unsigned cnt_width(input int unsigned din_w);
        return (din_w <= 2) ? 1 : $clog2(din_w);
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring radix-2 division step.
// Ports:
//   r_i       : partial remainder, one bit wider than the divisor
//   q_i       : quotient / remaining-dividend shift register
//   divisor_i : divisor
//   r_next_o  : partial remainder after shift and conditional subtract
//   q_next_o  : shift register with the new quotient bit in bit 0
module restoring_div_step #(
    parameter int unsigned DIN_W = 8
) (
    input  logic [DIN_W:0]   r_i,
    input  logic [DIN_W-1:0] q_i,
    input  logic [DIN_W-1:0] divisor_i,
    output logic [DIN_W:0]   r_next_o,
    output logic [DIN_W-1:0] q_next_o
);

    logic [DIN_W+1:0] shifted;
    logic [DIN_W+1:0] trial;
    logic             trial_ok;

    // Carry the full R into the subtraction so its sign bit is a true borrow.
    always_comb begin
        shifted  = {r_i, q_i[DIN_W-1]};
        trial    = shifted - {2'b00, divisor_i};
        trial_ok = ~trial[DIN_W+1];
        r_next_o = trial_ok ? trial[DIN_W:0] : shifted[DIN_W:0];
        q_next_o = {q_i[DIN_W-2:0], trial_ok};
    end

endmodule

// File: rtl/fast_divider.sv
// Iterative unsigned divider with a single-cycle early-out path.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   dividend_i        : DIVIDEND_W-bit unsigned dividend
//   divisor_i         : DIN_W-bit unsigned divisor
//   operands_valid_i  : operands present; accepted when operands_ready_o is high
//   operands_ready_o  : block idle and able to accept operands
//   quotient_o        : registered quotient
//   remainder_o       : registered remainder
//   result_valid_o    : one-cycle pulse per accepted operation
//   div_by_zero_o     : result qualifier, divisor was zero
//   overflow_o        : result qualifier, quotient did not fit in DIN_W bits
module fast_divider
    import divider_pkg::*;
#(
    parameter  int unsigned DIN_W      = 8,
    localparam int unsigned DIVIDEND_W = 2 * DIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIN_W-1:0]      divisor_i,
    input  logic                  operands_valid_i,
    output logic                  operands_ready_o,
    output logic [DIN_W-1:0]      quotient_o,
    output logic [DIN_W-1:0]      remainder_o,
    output logic                  result_valid_o,
    output logic                  div_by_zero_o,
    output logic                  overflow_o
);

    localparam int unsigned          CW       = cnt_width(DIN_W);
    localparam logic [CW-1:0]        LAST_CNT = CW'(DIN_W - 1);

    div_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DIN_W:0]     r_q, r_d;
    logic [DIN_W-1:0]   q_q, q_d;
    logic [DIN_W-1:0]   dvs_q, dvs_d;
    logic [DIN_W-1:0]   quo_q, quo_d;
    logic [DIN_W-1:0]   rem_q, rem_d;
    logic               valid_q, valid_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [DIN_W:0]     r_next;
    logic [DIN_W-1:0]   q_next;
    logic [DIN_W-1:0]   hi;
    logic               accept;

    restoring_div_step #(
        .DIN_W(DIN_W)
    ) u_step (
        .r_i       (r_q),
        .q_i       (q_q),
        .divisor_i (dvs_q),
        .r_next_o  (r_next),
        .q_next_o  (q_next)
    );

    assign hi               = dividend_i[DIVIDEND_W-1:DIN_W];
    assign operands_ready_o = (state_q == IDLE) && !rst;
    assign accept           = operands_valid_i && operands_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        valid_d = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (divisor_i == '0) begin
                        valid_d = 1'b1;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quo_d   = '1;
                        rem_d   = dividend_i[DIN_W-1:0];
                    end else if (hi >= divisor_i) begin
                        valid_d = 1'b1;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = '0;
                    end else if (dividend_i < DIVIDEND_W'(divisor_i)) begin
                        valid_d = 1'b1;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        quo_d   = '0;
                        rem_d   = dividend_i[DIN_W-1:0];
                    end else begin
                        // hi < divisor here, so the quotient fits in DIN_W bits.
                        r_d     = {1'b0, hi};
                        q_d     = dividend_i[DIN_W-1:0];
                        dvs_d   = divisor_i;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    quo_d   = q_next;
                    rem_d   = r_next[DIN_W-1:0];
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quotient_o     = quo_q;
    assign remainder_o    = rem_q;
    assign result_valid_o = valid_q;
    assign div_by_zero_o  = dbz_q;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_fast_divider.sv
// Directed self-checking bench for fast_divider (DIN_W = 8).
module tb_fast_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        res_valid;
    logic        dbz;
    logic        ovf;

    logic [8:0]  s_r, s_rn;
    logic [7:0]  s_q, s_qn, s_d;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    fast_divider #(
        .DIN_W(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dividend_i       (dividend),
        .divisor_i        (divisor),
        .operands_valid_i (op_valid),
        .operands_ready_o (op_ready),
        .quotient_o       (quotient),
        .remainder_o      (remainder),
        .result_valid_o   (res_valid),
        .div_by_zero_o    (dbz),
        .overflow_o       (ovf)
    );

    restoring_div_step #(
        .DIN_W(8)
    ) u_gold_step (
        .r_i       (s_r),
        .q_i       (s_q),
        .divisor_i (s_d),
        .r_next_o  (s_rn),
        .q_next_o  (s_qn)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                              input logic z, input logic o);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_quot"},  {24'd0, quotient},  {24'd0, q});
        chk({tag, "_rem"},   {24'd0, remainder}, {24'd0, r});
        chk({tag, "_dbz"},   {31'd0, dbz},       {31'd0, z});
        chk({tag, "_ovf"},   {31'd0, ovf},       {31'd0, o});
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] b);
        dividend = a;
        divisor  = b;
        op_valid = 1'b1;
    endtask

    // Waits out the 7 quiet CALC cycles after the accept edge, then the result edge.
    task automatic run_slow(input string tag);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk({tag, "_busy_valid"}, {31'd0, res_valid}, 32'd0);
            chk({tag, "_busy_ready"}, {31'd0, op_ready},  32'd0);
        end
        tick();
        chk({tag, "_done_ready"}, {31'd0, op_ready}, 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        dividend = '0;
        divisor  = '0;
        op_valid = 1'b0;
        s_r = '0; s_q = '0; s_d = '0;

        // Golden step chain: 1000/7 through 8 combinational iterations.
        s_r = 9'd3; s_q = 8'hE8; s_d = 8'd7;
        for (int i = 0; i < 8; i++) begin
            #1;
            s_r = s_rn;
            s_q = s_qn;
        end
        chk("step_chain_quot", {24'd0, s_q}, 32'd142);
        chk("step_chain_rem",  {23'd0, s_r}, 32'd6);

        // Reset state
        tick(); tick();
        chk("rst_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_quot",  {24'd0, quotient}, 32'd0);
        chk("rst_rem",   {24'd0, remainder}, 32'd0);
        chk("rst_flags", {30'd0, dbz, ovf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, op_ready}, 32'd1);

        // Slow path 1000/7
        drive(16'd1000, 8'd7);
        tick();
        op_valid = 1'b0;
        chk("slow1_ready_drop", {31'd0, op_ready}, 32'd0);
        chk("slow1_no_valid",   {31'd0, res_valid}, 32'd0);
        run_slow("slow1");
        chk_result("slow1", 8'd142, 8'd6, 1'b0, 1'b0);
        tick();
        chk("slow1_pulse_end", {31'd0, res_valid}, 32'd0);
        chk("slow1_hold_quot", {24'd0, quotient}, 32'd142);

        // Three back-to-back fast ops (dividend < divisor)
        drive(16'd5, 8'd9);
        tick();
        chk_result("fast_a", 8'd0, 8'd5, 1'b0, 1'b0);
        chk("fast_a_ready", {31'd0, op_ready}, 32'd1);
        drive(16'd3, 8'd200);
        tick();
        chk_result("fast_b", 8'd0, 8'd3, 1'b0, 1'b0);
        drive(16'd9, 8'd10);
        tick();
        chk_result("fast_c", 8'd0, 8'd9, 1'b0, 1'b0);
        op_valid = 1'b0;
        tick();
        chk("fast_pulse_end", {31'd0, res_valid}, 32'd0);

        // Divide by zero
        drive(16'd100, 8'd0);
        tick();
        op_valid = 1'b0;
        chk_result("dbz", 8'hFF, 8'd100, 1'b1, 1'b0);
        tick();
        chk("dbz_pulse_end", {31'd0, res_valid}, 32'd0);
        chk("dbz_hold_flag", {31'd0, dbz}, 32'd1);

        // Overflow: hi >= divisor, including the hi == divisor edge
        drive(16'h1234, 8'h10);
        tick();
        chk_result("ovf_a", 8'hFF, 8'd0, 1'b0, 1'b1);
        drive(16'h0100, 8'h01);
        tick();
        op_valid = 1'b0;
        chk_result("ovf_b", 8'hFF, 8'd0, 1'b0, 1'b1);

        // Largest non-overflowing case: hi == divisor-1
        drive(16'hFEFF, 8'hFF);
        tick();
        op_valid = 1'b0;
        run_slow("maxq");
        chk_result("maxq", 8'd255, 8'd254, 1'b0, 1'b0);

        // dividend == divisor takes the slow path
        drive(16'd9, 8'd9);
        tick();
        op_valid = 1'b0;
        run_slow("eq");
        chk_result("eq", 8'd1, 8'd0, 1'b0, 1'b0);

        // Valid held during a slow op: next operand accepted on the result cycle
        drive(16'd1000, 8'd7);
        tick();
        drive(16'd5, 8'd9);
        run_slow("held");
        chk_result("held_first", 8'd142, 8'd6, 1'b0, 1'b0);
        tick();
        op_valid = 1'b0;
        chk_result("held_second", 8'd0, 8'd5, 1'b0, 1'b0);
        tick();
        chk("held_pulse_end", {31'd0, res_valid}, 32'd0);

        // Load distinct nonzero outputs, then abort a slow op with reset
        drive(16'd100, 8'd0);
        tick();
        op_valid = 1'b0;
        chk_result("pre_abort", 8'hFF, 8'd100, 1'b1, 1'b0);
        drive(16'd1000, 8'd7);
        tick();
        op_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst", {31'd0, op_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", {31'd0, res_valid}, 32'd0);
        chk("abort_quot",  {24'd0, quotient}, 32'd0);
        chk("abort_rem",   {24'd0, remainder}, 32'd0);
        chk("abort_flags", {30'd0, dbz, ovf}, 32'd0);
        chk("abort_ready_after", {31'd0, op_ready}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_pulse", {31'd0, res_valid}, 32'd0);
        end
        drive(16'd1000, 8'd7);
        tick();
        op_valid = 1'b0;
        run_slow("post_abort");
        chk_result("post_abort", 8'd142, 8'd6, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
